// File: rtl/paeth_pred_stream.sv
// Paeth intra predictor: latches one block's edge pixels, streams PPC pixels/beat row-major.
// First beat 1 cycle after start accept, then 1 beat/cycle; output register holds while pred_ready is low.
module paeth_pred_stream #(
    parameter int BIT_DEPTH = 10,
    parameter int MAX_BLK   = 16,
    parameter int PPC       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           start_ready,
    input  logic [2:0]                     w_log2,
    input  logic [2:0]                     h_log2,
    input  logic [BIT_DEPTH-1:0]           referencePixel,
    input  logic [MAX_BLK*BIT_DEPTH-1:0]   aboveRow,
    input  logic [MAX_BLK*BIT_DEPTH-1:0]   leftCol,
    output logic [PPC*BIT_DEPTH-1:0]       pred_data,
    output logic                           pred_valid,
    input  logic                           pred_ready,
    output logic [$clog2(MAX_BLK)-1:0]     pred_x,
    output logic [$clog2(MAX_BLK)-1:0]     pred_y,
    output logic                           pred_last,
    output logic                           size_err
);
    localparam int LB = $clog2(MAX_BLK);
    localparam int CW = LB + 1;
    localparam int SW = BIT_DEPTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [BIT_DEPTH-1:0]         tl_q;
    logic [MAX_BLK*BIT_DEPTH-1:0] above_q;
    logic [MAX_BLK*BIT_DEPTH-1:0] left_q;
    logic [2:0]                   wl_q;
    logic [2:0]                   hl_q;
    logic [LB-1:0]                cx;
    logic [LB-1:0]                cy;

    logic                         size_ok;
    logic                         advance;
    logic                         row_end;
    logic                         last_beat;
    logic [CW-1:0]                x_next;
    logic [CW-1:0]                width_c;
    logic [CW-1:0]                hmax;
    logic [PPC*BIT_DEPTH-1:0]     beat;

    // Distances in the delta form: pL=|T-TL|, pT=|L-TL|, pTL=|T+L-2TL|.
    function automatic logic [BIT_DEPTH-1:0] paeth(input logic [BIT_DEPTH-1:0] t,
                                                   input logic [BIT_DEPTH-1:0] l,
                                                   input logic [BIT_DEPTH-1:0] c);
        logic signed [SW-1:0] dt;
        logic signed [SW-1:0] dl;
        logic signed [SW-1:0] ds;
        logic [SW-1:0]        p_l;
        logic [SW-1:0]        p_t;
        logic [SW-1:0]        p_tl;
        dt   = $signed({2'b00, t}) - $signed({2'b00, c});
        dl   = $signed({2'b00, l}) - $signed({2'b00, c});
        ds   = dt + dl;
        p_l  = (dt < 0) ? -dt : dt;
        p_t  = (dl < 0) ? -dl : dl;
        p_tl = (ds < 0) ? -ds : ds;
        if (p_l <= p_t && p_l <= p_tl)
            return l;
        else if (p_t <= p_tl)
            return t;
        else
            return c;
    endfunction

    assign size_ok = (w_log2 >= 3'd2) && (w_log2 <= 3'(LB)) &&
                     (h_log2 >= 3'd2) && (h_log2 <= 3'(LB));
    assign start_ready = (state == IDLE);
    assign advance   = (state == RUN) && (!pred_valid || pred_ready);
    assign x_next    = {1'b0, cx} + CW'(PPC);
    assign width_c   = CW'(1) << wl_q;
    assign hmax      = (CW'(1) << hl_q) - CW'(1);
    assign row_end   = (x_next == width_c);
    assign last_beat = row_end && ({1'b0, cy} == hmax);

    always_comb begin
        beat = '0;
        for (int p = 0; p < PPC; p++) begin
            beat[p*BIT_DEPTH +: BIT_DEPTH] =
                paeth(above_q[(int'(cx) + p)*BIT_DEPTH +: BIT_DEPTH],
                      left_q[int'(cy)*BIT_DEPTH +: BIT_DEPTH], tl_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tl_q       <= '0;
            above_q    <= '0;
            left_q     <= '0;
            wl_q       <= '0;
            hl_q       <= '0;
            cx         <= '0;
            cy         <= '0;
            pred_data  <= '0;
            pred_valid <= 1'b0;
            pred_x     <= '0;
            pred_y     <= '0;
            pred_last  <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            size_err <= start && (state == IDLE) && !size_ok;
            case (state)
                IDLE: begin
                    if (start && size_ok) begin
                        tl_q    <= referencePixel;
                        above_q <= aboveRow;
                        left_q  <= leftCol;
                        wl_q    <= w_log2;
                        hl_q    <= h_log2;
                        cx      <= '0;
                        cy      <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        pred_data  <= beat;
                        pred_x     <= cx;
                        pred_y     <= cy;
                        pred_valid <= 1'b1;
                        pred_last  <= last_beat;
                        if (last_beat) begin
                            state <= DRAIN;
                        end else if (row_end) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= x_next[LB-1:0];
                        end
                    end
                end
                DRAIN: begin
                    // Only the last beat is outstanding here.
                    if (pred_ready) begin
                        pred_valid <= 1'b0;
                        pred_last  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_paeth_pred_stream.sv
// Directed bench for paeth_pred_stream (BIT_DEPTH=10, MAX_BLK=16, PPC=4).
module tb_paeth_pred_stream;
    localparam int BD = 10;
    localparam int MB = 16;
    localparam int PPC = 4;
    localparam int DW = PPC*BD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start_ready;
    logic [2:0]    w_log2 = 3'd2;
    logic [2:0]    h_log2 = 3'd2;
    logic [BD-1:0] referencePixel = '0;
    logic [MB*BD-1:0] aboveRow = '0;
    logic [MB*BD-1:0] leftCol = '0;
    logic [DW-1:0] pred_data;
    logic          pred_valid;
    logic          pred_ready = 1'b1;
    logic [3:0]    pred_x;
    logic [3:0]    pred_y;
    logic          pred_last;
    logic          size_err;

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_b [0:63];

    paeth_pred_stream #(.BIT_DEPTH(BD), .MAX_BLK(MB), .PPC(PPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .w_log2(w_log2), .h_log2(h_log2), .referencePixel(referencePixel),
        .aboveRow(aboveRow), .leftCol(leftCol), .pred_data(pred_data),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_x(pred_x),
        .pred_y(pred_y), .pred_last(pred_last), .size_err(size_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pk4(input int a, input int b, input int c, input int d);
        return {BD'(d), BD'(c), BD'(b), BD'(a)};
    endfunction

    // Reference written in the base-distance form: base=T+L-TL.
    function automatic int ref_pix(input int t, input int l, input int c);
        int base, pa, pb, pc;
        base = t + l - c;
        pa = (base > l) ? base - l : l - base;
        pb = (base > t) ? base - t : t - base;
        pc = (base > c) ? base - c : c - base;
        if (pa <= pb && pa <= pc) return l;
        if (pb <= pc) return t;
        return c;
    endfunction

    task automatic set_edges(input int a[16], input int l[16], input int t);
        for (int i = 0; i < MB; i++) begin
            aboveRow[i*BD +: BD] = BD'(a[i]);
            leftCol[i*BD +: BD]  = BD'(l[i]);
        end
        referencePixel = BD'(t);
    endtask

    task automatic build_exp(input int a[16], input int l[16], input int t, input int wl, input int hl);
        int w, idx;
        w = 1 << wl;
        idx = 0;
        for (int y = 0; y < (1 << hl); y++)
            for (int x = 0; x < w; x += PPC) begin
                for (int p = 0; p < PPC; p++)
                    exp_b[idx][p*BD +: BD] = BD'(ref_pix(a[x+p], l[y], t));
                idx++;
            end
    endtask

    // mode 0: pred_ready always high; mode 1: pseudo-random ready.
    task automatic collect(input string tag, input int wl, input int hl, input int mode, output int cycles);
        int i, n, w;
        logic stalled;
        logic [63:0] held;
        i = 0;
        w = 1 << wl;
        n = (1 << wl) * (1 << hl) / PPC;
        stalled = 1'b0;
        held = '0;
        cycles = 0;
        while (i < n && cycles < 2000) begin
            pred_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (stalled)
                check({tag, "_hold"}, 64'({pred_last, pred_y, pred_x, pred_data}), held);
            if (pred_valid && pred_ready) begin
                check({tag, "_data"}, 64'(pred_data), 64'(exp_b[i]));
                check({tag, "_x"}, 64'(pred_x), 64'((i*PPC) % w));
                check({tag, "_y"}, 64'(pred_y), 64'((i*PPC) / w));
                check({tag, "_last"}, 64'(pred_last), 64'(i == n-1));
                i++;
                stalled = 1'b0;
            end else if (pred_valid) begin
                stalled = 1'b1;
                held = 64'({pred_last, pred_y, pred_x, pred_data});
            end
            step();
            cycles++;
        end
        pred_ready = 1'b1;
        check({tag, "_beats"}, 64'(i), 64'(n));
        check({tag, "_drained"}, 64'(pred_valid), 64'(0));
    endtask

    int a1[16], l1[16], a2[16], l2[16], a3[16], l3[16];
    int cyc, seen;

    initial begin
        for (int i = 0; i < 16; i++) begin
            a1[i] = 0; l1[i] = 0;
            a2[i] = 200; l2[i] = 100;
            a3[i] = (i*97 + 13) % 1024; l3[i] = (i*211 + 500) % 1024;
        end
        a1[0] = 140; a1[1] = 235; a1[2] = 101; a1[3] = 56;
        l1[0] = 5;   l1[1] = 170; l1[2] = 12;  l1[3] = 230;

        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_start_ready", 64'(start_ready), 1);
        check("rst_valid", 64'(pred_valid), 0);
        check("rst_last", 64'(pred_last), 0);
        check("rst_data", 64'(pred_data), 0);
        check("rst_xy", 64'({pred_x, pred_y}), 0);
        check("rst_size_err", 64'(size_err), 0);

        // 4x4 hand-computed block
        set_edges(a1, l1, 150);
        exp_b[0] = pk4(5, 150, 5, 5);
        exp_b[1] = pk4(170, 235, 101, 56);
        exp_b[2] = pk4(12, 150, 12, 12);
        exp_b[3] = pk4(230, 235, 150, 150);
        w_log2 = 3'd2; h_log2 = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("b4_ready_drop", 64'(start_ready), 0);
        check("b4_no_early_valid", 64'(pred_valid), 0);
        step();
        check("b4_first_valid", 64'(pred_valid), 1);
        collect("b4", 2, 2, 0, cyc);
        check("b4_cycles", 64'(cyc), 4);
        check("b4_idle_ready", 64'(start_ready), 1);

        // 16x8 uniform block
        set_edges(a2, l2, 100);
        for (int i = 0; i < 32; i++) exp_b[i] = pk4(200, 200, 200, 200);
        w_log2 = 3'd4; h_log2 = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        collect("b16x8", 4, 3, 0, cyc);
        check("b16x8_cycles", 64'(cyc), 33);

        // 8x8 with random backpressure
        set_edges(a3, l3, 512);
        build_exp(a3, l3, 512, 3, 3);
        w_log2 = 3'd3; h_log2 = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        collect("bp8x8", 3, 3, 1, cyc);

        // Illegal sizes
        w_log2 = 3'd1; h_log2 = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("ill1_err", 64'(size_err), 1);
        check("ill1_ready", 64'(start_ready), 1);
        step();
        check("ill1_pulse", 64'(size_err), 0);
        check("ill1_valid", 64'(pred_valid), 0);
        w_log2 = 3'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("ill5_err", 64'(size_err), 1);
        check("ill5_ready", 64'(start_ready), 1);
        step();
        check("ill5_pulse", 64'(size_err), 0);
        check("ill5_valid", 64'(pred_valid), 0);

        // Back-to-back with start held; edges change mid-block
        set_edges(a1, l1, 150);
        build_exp(a1, l1, 150, 2, 2);
        w_log2 = 3'd2; h_log2 = 3'd2; start = 1'b1;
        step();
        set_edges(a3, l3, 300);
        collect("bb1", 2, 2, 0, cyc);
        check("bb_ready_between", 64'(start_ready), 1);
        build_exp(a3, l3, 300, 2, 2);
        step();
        start = 1'b0;
        check("bb_second_accept", 64'(start_ready), 0);
        check("bb_no_interleave", 64'(pred_valid), 0);
        collect("bb2", 2, 2, 0, cyc);

        // Reset mid-RUN
        set_edges(a3, l3, 512);
        w_log2 = 3'd3; h_log2 = 3'd3; start = 1'b1; pred_ready = 1'b0;
        step();
        start = 1'b0;
        step(); step();
        check("mid_valid_before", 64'(pred_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pred_valid), 0);
        check("mid_rst_last", 64'(pred_last), 0);
        step();
        rst_n = 1'b1;
        pred_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pred_valid) seen++;
        end
        check("mid_no_beats", 64'(seen), 0);
        check("mid_start_ready", 64'(start_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
